// File: rtl/ir_pkg.sv
// Shared IR receiver types: FSM state encoding and NEC duration windows in sample ticks.
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      REP_STOP
   } ir_state_t;

   localparam logic [8:0] LEAD_MARK_MIN  = 9'd160;
   localparam logic [8:0] LEAD_MARK_MAX  = 9'd200;
   localparam logic [8:0] LEAD_SPACE_MIN = 9'd80;
   localparam logic [8:0] LEAD_SPACE_MAX = 9'd100;
   localparam logic [8:0] REP_SPACE_MIN  = 9'd36;
   localparam logic [8:0] REP_SPACE_MAX  = 9'd54;
   localparam logic [8:0] BIT_MARK_MIN   = 9'd8;
   localparam logic [8:0] BIT_MARK_MAX   = 9'd14;
   localparam logic [8:0] ZERO_SPACE_MIN = 9'd8;
   localparam logic [8:0] ZERO_SPACE_MAX = 9'd16;
   localparam logic [8:0] ONE_SPACE_MIN  = 9'd28;
   localparam logic [8:0] ONE_SPACE_MAX  = 9'd40;

   function automatic logic in_win(input logic [8:0] d, input logic [8:0] lo, input logic [8:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Sample tick divider plus 2-flop synchroniser; level is the mark=1 input captured with each tick.
// tick and level are registered together, so level is fresh in the cycle tick is high.
module ir_tick_gen #(
   parameter int TICK_DIV   = 1250,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk25,
   input  logic rst,
   input  logic ir_in,
   output logic tick,
   output logic level
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [1:0]    sync;
   logic          at_end;

   assign at_end = (cnt == CW'(TICK_DIV - 1));

   // Synchroniser resets to the idle pin level so no phantom mark appears after reset.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         sync  <= {2{ACTIVE_LOW}};
         cnt   <= '0;
         tick  <= 1'b0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], ir_in};
         cnt  <= at_end ? '0 : cnt + CW'(1);
         tick <= at_end;
         if (at_end)
            level <= sync[1] ^ ACTIVE_LOW;
      end
   end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame/repeat decoder: one-cycle valid/repeat_o/err strobes registered after the deciding tick.
// No backpressure; results and last-frame data are held until the next accepted frame.
module ir_nec_rx import ir_pkg::*; #(
   parameter int         TICK_DIV   = 1250,
   parameter bit         ACTIVE_LOW = 1'b1,
   parameter logic [1:0] CHECK_INV  = 2'b11
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic        enable,
   input  logic        ir_in,
   output logic        valid,
   output logic        repeat_o,
   output logic        err,
   output logic [7:0]  addr,
   output logic [7:0]  cmd,
   output logic [31:0] raw,
   output logic        busy
);
   ir_state_t   state, state_d;
   logic        tick, level, prev_level, edge_seen, saturated;
   logic [7:0]  dur;
   logic [8:0]  dur_len;
   logic [31:0] sr;
   logic [5:0]  bit_cnt;
   logic        last_ok, frame_ok;
   logic        do_valid, do_rep, do_err, do_clr_ok, shift_en, shift_bit;

   ir_tick_gen #(.TICK_DIV(TICK_DIV), .ACTIVE_LOW(ACTIVE_LOW)) u_tick (
      .clk25 (clk25),
      .rst   (rst),
      .ir_in (ir_in),
      .tick  (tick),
      .level (level)
   );

   // dur counts samples after the first one of a level, so the finished level lasted dur+1 ticks.
   assign edge_seen = (level != prev_level);
   assign dur_len   = {1'b0, dur} + 9'd1;
   assign saturated = (dur == 8'hFF) && !edge_seen;
   assign frame_ok  = (!CHECK_INV[0] || (sr[15:8]  == ~sr[7:0])) &&
                      (!CHECK_INV[1] || (sr[31:24] == ~sr[23:16]));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d   = state;
      do_valid  = 1'b0;
      do_rep    = 1'b0;
      do_err    = 1'b0;
      do_clr_ok = 1'b0;
      shift_en  = 1'b0;
      shift_bit = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else if (tick) begin
         if (state != IDLE && saturated) begin
            do_err  = 1'b1;
            state_d = IDLE;
         end else begin
            case (state)
               IDLE:       if (level) state_d = LEAD_MARK;
               LEAD_MARK:  if (edge_seen) begin
                  if (in_win(dur_len, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
                  else begin do_err = 1'b1; state_d = IDLE; end
               end
               LEAD_SPACE: if (edge_seen) begin
                  if (in_win(dur_len, LEAD_SPACE_MIN, LEAD_SPACE_MAX))     state_d = BIT_MARK;
                  else if (in_win(dur_len, REP_SPACE_MIN, REP_SPACE_MAX)) state_d = REP_STOP;
                  else begin do_err = 1'b1; state_d = IDLE; end
               end
               BIT_MARK:   if (edge_seen) begin
                  if (in_win(dur_len, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
                  else begin do_err = 1'b1; state_d = IDLE; end
               end
               BIT_SPACE:  if (edge_seen) begin
                  if (in_win(dur_len, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) shift_en = 1'b1;
                  else if (in_win(dur_len, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                     shift_en  = 1'b1;
                     shift_bit = 1'b1;
                  end else begin
                     do_err  = 1'b1;
                     state_d = IDLE;
                  end
                  if (shift_en) state_d = (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
               end
               STOP_MARK:  if (edge_seen) begin
                  state_d = IDLE;
                  if (in_win(dur_len, BIT_MARK_MIN, BIT_MARK_MAX) && frame_ok) do_valid = 1'b1;
                  else begin
                     do_err    = 1'b1;
                     do_clr_ok = in_win(dur_len, BIT_MARK_MIN, BIT_MARK_MAX);
                  end
               end
               REP_STOP:   if (edge_seen) begin
                  state_d = IDLE;
                  if (in_win(dur_len, BIT_MARK_MIN, BIT_MARK_MAX) && last_ok) do_rep = 1'b1;
                  else do_err = 1'b1;
               end
               default:    state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         prev_level <= 1'b0;
         dur        <= '0;
      end else if (tick) begin
         prev_level <= level;
         if (edge_seen)          dur <= '0;
         else if (dur != 8'hFF)  dur <= dur + 8'd1;
      end
   end

   // Shift register fills from the MSB side, so the first received bit ends up in raw[0].
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         sr       <= '0;
         bit_cnt  <= '0;
         valid    <= 1'b0;
         repeat_o <= 1'b0;
         err      <= 1'b0;
         addr     <= '0;
         cmd      <= '0;
         raw      <= '0;
         last_ok  <= 1'b0;
      end else begin
         valid    <= do_valid;
         repeat_o <= do_rep;
         err      <= do_err;
         if (state_d == IDLE) begin
            sr      <= '0;
            bit_cnt <= '0;
         end else if (shift_en) begin
            sr      <= {shift_bit, sr[31:1]};
            bit_cnt <= bit_cnt + 6'd1;
         end
         if (do_valid) begin
            raw     <= sr;
            addr    <= sr[7:0];
            cmd     <= sr[23:16];
            last_ok <= 1'b1;
         end else if (do_clr_ok) begin
            last_ok <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ir_nec_rx.sv
// Scoreboard bench: two decoders (full and address-only inverse check) share the IR pin.
module tb_ir_nec_rx;
   localparam int TD = 2;
   localparam logic [1:0] K_VAL = 2'd0, K_REP = 2'd1, K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [7:0]  cmd;
      logic [31:0] raw;
   } evt_t;

   logic clk25 = 1'b0;
   logic rst, enable, ir_in;
   logic valid_a, rep_a, err_a, busy_a, valid_b, rep_b, err_b, busy_b;
   logic [7:0]  addr_a, cmd_a, addr_b, cmd_b;
   logic [31:0] raw_a, raw_b;

   evt_t q_a[$];
   evt_t q_b[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #20 clk25 = ~clk25;

   ir_nec_rx #(.TICK_DIV(TD), .ACTIVE_LOW(1'b1), .CHECK_INV(2'b11)) dut_a (
      .clk25(clk25), .rst(rst), .enable(enable), .ir_in(ir_in),
      .valid(valid_a), .repeat_o(rep_a), .err(err_a),
      .addr(addr_a), .cmd(cmd_a), .raw(raw_a), .busy(busy_a)
   );

   ir_nec_rx #(.TICK_DIV(TD), .ACTIVE_LOW(1'b1), .CHECK_INV(2'b01)) dut_b (
      .clk25(clk25), .rst(rst), .enable(enable), .ir_in(ir_in),
      .valid(valid_b), .repeat_o(rep_b), .err(err_b),
      .addr(addr_b), .cmd(cmd_b), .raw(raw_b), .busy(busy_b)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic evt_t mk(input logic [1:0] k, input logic [7:0] a, input logic [7:0] c,
                               input logic [31:0] r);
      evt_t e;
      e.kind = k; e.addr = a; e.cmd = c; e.raw = r;
      return e;
   endfunction

   task automatic expect_ab(input evt_t ea, input evt_t eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
   endtask

   always @(negedge clk25) begin : mon_a
      evt_t e;
      if (valid_a || rep_a || err_a) begin
         cmp("a_onehot", 32'($onehot({valid_a, rep_a, err_a})), 32'd1);
         if (q_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_unexpected: strobe v%b r%b e%b with nothing queued", valid_a, rep_a, err_a);
         end else begin
            e = q_a.pop_front();
            cmp("a_kind", 32'(valid_a ? K_VAL : rep_a ? K_REP : K_ERR), 32'(e.kind));
            cmp("a_addr", 32'(addr_a), 32'(e.addr));
            cmp("a_cmd",  32'(cmd_a),  32'(e.cmd));
            cmp("a_raw",  raw_a, e.raw);
         end
      end
   end

   always @(negedge clk25) begin : mon_b
      evt_t e;
      if (valid_b || rep_b || err_b) begin
         cmp("b_onehot", 32'($onehot({valid_b, rep_b, err_b})), 32'd1);
         if (q_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected: strobe v%b r%b e%b with nothing queued", valid_b, rep_b, err_b);
         end else begin
            e = q_b.pop_front();
            cmp("b_kind", 32'(valid_b ? K_VAL : rep_b ? K_REP : K_ERR), 32'(e.kind));
            cmp("b_addr", 32'(addr_b), 32'(e.addr));
            cmp("b_cmd",  32'(cmd_b),  32'(e.cmd));
            cmp("b_raw",  raw_b, e.raw);
         end
      end
   end

   task automatic hold(input logic mark, input int ticks);
      ir_in = !mark;
      repeat (ticks * TD) @(negedge clk25);
   endtask

   // Stops after the mark of abort_bit (leaving the pin in mark) when abort_bit < 32.
   task automatic send_frame(input logic [31:0] w, input int lm, input int ls, input int bm,
                             input int s0, input int s1, input int stretch_bit,
                             input int stretch_len, input int abort_bit);
      hold(1'b1, lm);
      hold(1'b0, ls);
      for (int i = 0; i < 32; i++) begin
         hold(1'b1, (i == stretch_bit) ? stretch_len : bm);
         if (i == abort_bit) return;
         hold(1'b0, w[i] ? s1 : s0);
      end
      hold(1'b1, bm);
      hold(1'b0, 60);
   endtask

   task automatic send_nom(input logic [31:0] w);
      send_frame(w, 180, 90, 11, 11, 34, -1, 11, 99);
   endtask

   task automatic send_repeat(input int gap);
      hold(1'b1, 180);
      hold(1'b0, 45);
      hold(1'b1, 11);
      hold(1'b0, gap);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 400 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk25);
      cmp(name, 32'(q_a.size() + q_b.size()), 32'd0);
      q_a.delete();
      q_b.delete();
   endtask

   task automatic check_zero(input string name);
      cmp({name, "_strobes"}, {26'd0, valid_a, rep_a, err_a, valid_b, rep_b, err_b}, 32'd0);
      cmp({name, "_busy"}, {30'd0, busy_a, busy_b}, 32'd0);
      cmp({name, "_addrcmd"}, {addr_a, cmd_a, addr_b, cmd_b}, 32'd0);
      cmp({name, "_raw_a"}, raw_a, 32'd0);
      cmp({name, "_raw_b"}, raw_b, 32'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; ir_in = 1'b1;
      repeat (5) @(negedge clk25);
      check_zero("reset");
      rst = 1'b0;
      hold(1'b0, 20);
      check_zero("post_reset");

      // Repeat with no prior frame is an error on both
      expect_ab(mk(K_ERR, 8'h00, 8'h00, 32'h0), mk(K_ERR, 8'h00, 8'h00, 32'h0));
      send_repeat(60);
      drain("rep_after_reset");

      expect_ab(mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04), mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04));
      send_nom(32'hF708FB04);
      drain("frame_nominal");

      expect_ab(mk(K_REP, 8'h04, 8'h08, 32'hF708FB04), mk(K_REP, 8'h04, 8'h08, 32'hF708FB04));
      hold(1'b0, 800);
      send_repeat(60);
      drain("repeat_after_frame");

      // cmd_inv = 0x00: full check rejects, address-only check accepts
      expect_ab(mk(K_ERR, 8'h04, 8'h08, 32'hF708FB04), mk(K_VAL, 8'h04, 8'h08, 32'h0008FB04));
      send_nom(32'h0008FB04);
      drain("bad_cmd_inv");

      expect_ab(mk(K_ERR, 8'h04, 8'h08, 32'hF708FB04), mk(K_REP, 8'h04, 8'h08, 32'h0008FB04));
      send_repeat(60);
      drain("repeat_after_check_fail");

      expect_ab(mk(K_ERR, 8'h04, 8'h08, 32'hF708FB04), mk(K_ERR, 8'h04, 8'h08, 32'h0008FB04));
      send_frame(32'h7F80BF40, 180, 90, 11, 11, 34, 10, 20, 10);
      hold(1'b0, 100);
      drain("stretched_bit_mark");
      cmp("busy_after_err", {30'd0, busy_a, busy_b}, 32'd0);

      expect_ab(mk(K_VAL, 8'h40, 8'h80, 32'h7F80BF40), mk(K_VAL, 8'h40, 8'h80, 32'h7F80BF40));
      send_frame(32'h7F80BF40, 160, 80, 8, 16, 28, -1, 8, 99);
      drain("frame_low_edges");

      expect_ab(mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04), mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04));
      send_frame(32'hF708FB04, 200, 100, 14, 8, 40, -1, 14, 99);
      drain("frame_high_edges");

      expect_ab(mk(K_ERR, 8'h04, 8'h08, 32'hF708FB04), mk(K_ERR, 8'h04, 8'h08, 32'hF708FB04));
      hold(1'b1, 159);
      hold(1'b0, 100);
      drain("leader_too_short");

      send_frame(32'h7F80BF40, 180, 90, 11, 11, 34, -1, 11, 16);
      cmp("busy_mid_frame", {30'd0, busy_a, busy_b}, 32'd3);
      rst = 1'b1;
      repeat (10) @(negedge clk25);
      check_zero("mid_frame_reset");
      ir_in = 1'b1;
      rst = 1'b0;
      hold(1'b0, 50);
      expect_ab(mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04), mk(K_VAL, 8'h04, 8'h08, 32'hF708FB04));
      send_nom(32'hF708FB04);
      drain("frame_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
